mux_scan_seq: RTL

//  Select sequencer and frame capture for the 4:1 structural mux stage.

---
 rtl/mux_scan_seq_pkg.sv | 19 +
 rtl/mux_scan_seq_if.sv | 12 +
 rtl/mux_scan_seq_settle_cnt.sv | 35 +++
 rtl/mux_scan_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mux_scan_seq_pkg.sv
// rtl/mux_scan_seq_pkg.sv - shared types and constants for the mux scan sequencer
package mux_scan_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // Frame bit written for a given select: sel 00 reads in[3], sel 11 reads in[0]
    function automatic logic [SEL_W-1:0] ch_bit(input logic [SEL_W-1:0] s);
        return SEL_W'(NUM_CH - 1) - s;
    endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// rtl/mux_scan_seq_if.sv - captured-frame valid/ready handshake
interface mux_scan_seq_if;
    import mux_scan_seq_pkg::*;

    logic [NUM_CH-1:0] frame;
    logic              frame_valid;
    logic              frame_ready;

    modport master (output frame, output frame_valid, input frame_ready);
    modport slave  (input frame, input frame_valid, output frame_ready);

endinterface

// File: rtl/mux_scan_seq_settle_cnt.sv
// rtl/mux_scan_seq_settle_cnt.sv - 4-bit loadable down-counter timing the select settle
module mux_scan_seq_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load has priority; decrement stops at zero so done stays asserted
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - 4:1 mux select sequencer with frame capture and valid/ready output
module mux_scan_seq
    import mux_scan_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              mux_o,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    mux_scan_seq_if.master    frame_if
);

    // A zero settle time skips SETTLE entirely; otherwise the counter holds SETTLE_CYC cycles
    localparam bit         SKIP_SETTLE = (SETTLE_CYC == 0);
    localparam logic [3:0] SETTLE_LOAD = SKIP_SETTLE ? 4'd0 : 4'(SETTLE_CYC - 1);
    localparam state_e     SCAN_ENTRY  = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0]  frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               settle_load;
    logic               settle_done;
    logic               handshake;

    assign handshake = frame_valid_q && frame_if.frame_ready;

    mux_scan_seq_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .en       (state_q == ST_SETTLE),
        .done     (settle_done)
    );

    // Next-state logic: abort wins over the scan, but an accepted frame still counts
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        frame_cnt_d   = frame_cnt_q;
        settle_load   = 1'b0;

        if (handshake) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        if (abort) begin
            state_d       = ST_IDLE;
            sel_d         = '0;
            frame_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_d       = '0;
                        state_d     = SCAN_ENTRY;
                        settle_load = !SKIP_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    frame_d[ch_bit(sel_q)] = mux_o;
                    if (sel_q != SEL_LAST) begin
                        sel_d       = sel_q + 1'b1;
                        state_d     = SCAN_ENTRY;
                        settle_load = !SKIP_SETTLE;
                    end else begin
                        state_d       = ST_HOLD;
                        frame_valid_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        frame_valid_d = 1'b0;
                        if (cont) begin
                            sel_d       = '0;
                            state_d     = SCAN_ENTRY;
                            settle_load = !SKIP_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign sel                  = sel_q;
    assign busy                 = (state_q != ST_IDLE);
    assign frame_cnt            = frame_cnt_q;
    assign frame_if.frame       = frame_q;
    assign frame_if.frame_valid = frame_valid_q;

endmodule
